// File: rtl/aes_key_expander_if.sv
// Bundles the key-expander request and result signals.
// Bus widths follow the key length and round count.
interface aes_key_expander_if #(
    parameter int unsigned nk = 8,
    parameter int unsigned nb = 4,
    parameter int unsigned nr = 14
);
    logic                        start;
    logic [32*nk-1:0]            key_in;
    logic                        busy;
    logic                        done;
    logic                        key_valid;
    logic [32*nb*(nr+1)-1:0]     w;

    modport master (
        output start, key_in,
        input  busy, done, key_valid, w
    );

    modport slave (
        input  start, key_in,
        output busy, done, key_valid, w
    );
endinterface

// File: rtl/aes_key_expander.sv
// Sequential AES key schedule: latches the cipher key on start, then writes
// one round-key word per clock and holds the full schedule on w once done.
module aes_key_expander #(
    parameter int unsigned nk = 8,
    parameter int unsigned nb = 4,
    parameter int unsigned nr = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    aes_key_expander_if.slave bus
);

    localparam int unsigned total = nb * (nr + 1);
    localparam int unsigned iw    = $clog2(total + 1);
    localparam int unsigned kw    = $clog2(nk);
    localparam int unsigned ww    = 32 * total;

    generate
        if (!(nb == 4 && ((nk == 4 && nr == 10) || (nk == 6 && nr == 12) ||
                          (nk == 8 && nr == 14)))) begin : g_bad_params
            $error("aes_key_expander: unsupported nk/nb/nr combination");
        end
    endgenerate

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[8*(8'd255 - b) +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [iw-1:0]   i_q, i_d;
    logic [kw-1:0]   k_q, k_d;
    logic [7:0]      rcon_q, rcon_d;
    logic [ww-1:0]   w_q, w_d;
    logic            done_q, done_d;
    logic [31:0]     prev_word;
    logic [31:0]     back_word;
    logic [31:0]     temp;

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        k_d       = k_q;
        rcon_d    = rcon_q;
        w_d       = w_q;
        done_d    = 1'b0;

        prev_word = w_q[32*(i_q - iw'(1)) +: 32];
        back_word = w_q[32*(i_q - iw'(nk)) +: 32];
        temp      = prev_word;
        // k tracks i mod nk without a divider
        if (k_q == '0) begin
            temp = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon_q, 24'h0};
        end else if (nk > 6 && k_q == kw'(4)) begin
            temp = sub_word(prev_word);
        end

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    for (int unsigned j = 0; j < nk; j++) begin
                        w_d[32*j +: 32] = bus.key_in[32*(nk-1-j) +: 32];
                    end
                    i_d     = iw'(nk);
                    k_d     = '0;
                    rcon_d  = 8'h01;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                w_d[32*i_q +: 32] = back_word ^ temp;
                i_d = i_q + 1'b1;
                k_d = (k_q == kw'(nk - 1)) ? '0 : k_q + 1'b1;
                if (k_q == '0) begin
                    rcon_d = xtime(rcon_q);
                end
                if (i_q == iw'(total - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            k_q     <= '0;
            rcon_q  <= 8'h01;
            w_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            k_q     <= k_d;
            rcon_q  <= rcon_d;
            w_q     <= w_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy      = (state_q == EXPAND);
    assign bus.done      = done_q;
    assign bus.key_valid = (state_q == DONE);
    assign bus.w         = w_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: AES-128/192/256 instances checked against a
// behavioural key schedule and cipher built from GF(2^8) arithmetic.
module tb_aes_key_expander;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  tb_sbox [256];
    logic [31:0] ref_w   [60];
    logic [31:0] rk      [60];

    aes_key_expander_if #(.nk(4), .nb(4), .nr(10)) bus128 ();
    aes_key_expander_if #(.nk(6), .nb(4), .nr(12)) bus192 ();
    aes_key_expander_if #(.nk(8), .nb(4), .nr(14)) bus256 ();

    aes_key_expander #(.nk(4), .nb(4), .nr(10)) dut128 (.clk(clk), .rst_n(rst_n), .bus(bus128));
    aes_key_expander #(.nk(6), .nb(4), .nr(12)) dut192 (.clk(clk), .rst_n(rst_n), .bus(bus192));
    aes_key_expander #(.nk(8), .nb(4), .nr(14)) dut256 (.clk(clk), .rst_n(rst_n), .bus(bus256));

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int n = 0; n < 8; n++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from multiplicative inverse plus affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            tb_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_w(input logic [31:0] t);
        return {tb_sbox[t[31:24]], tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]]};
    endfunction

    task automatic ref_expand(input int nk, input logic [255:0] key);
        int total;
        logic [31:0] t;
        logic [7:0] rc;
        total = 4 * (nk + 7);
        rc = 8'h01;
        for (int i = 0; i < nk; i++) ref_w[i] = key[255-32*i -: 32];
        for (int i = nk; i < total; i++) begin
            t = ref_w[i-1];
            if (i % nk == 0) begin
                t = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_w(t);
            end
            ref_w[i] = ref_w[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [127:0] ct;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
        for (int rnd = 0; rnd <= 14; rnd++) begin
            if (rnd > 0) begin
                for (int i = 0; i < 16; i++) s[i] = tb_sbox[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
                if (rnd < 14) begin
                    for (int c = 0; c < 4; c++) begin
                        s[4*c]   = gmul(t[4*c], 8'd2) ^ gmul(t[4*c+1], 8'd3) ^ t[4*c+2] ^ t[4*c+3];
                        s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'd2) ^ gmul(t[4*c+2], 8'd3) ^ t[4*c+3];
                        s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'd2) ^ gmul(t[4*c+3], 8'd3);
                        s[4*c+3] = gmul(t[4*c], 8'd3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'd2);
                    end
                end else begin
                    for (int i = 0; i < 16; i++) s[i] = t[i];
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ rk[4*rnd+c][31-8*r -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
        return ct;
    endfunction

    // Drivers: pulse start for one cycle, return cycles from E0 to done (-1 on timeout)
    task automatic run128(input logic [255:0] key, output int lat);
        @(negedge clk); bus128.key_in = key[255:128]; bus128.start = 1'b1;
        @(posedge clk); @(negedge clk); bus128.start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus128.done) begin lat = c; break; end
        end
    endtask

    task automatic run192(input logic [255:0] key, output int lat);
        @(negedge clk); bus192.key_in = key[255:64]; bus192.start = 1'b1;
        @(posedge clk); @(negedge clk); bus192.start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus192.done) begin lat = c; break; end
        end
    endtask

    task automatic run256(input logic [255:0] key, output int lat);
        @(negedge clk); bus256.key_in = key; bus256.start = 1'b1;
        @(posedge clk); @(negedge clk); bus256.start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus256.done) begin lat = c; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus128.start = 1'b0; bus192.start = 1'b0; bus256.start = 1'b0;
        bus128.key_in = '0;  bus192.key_in = '0;  bus256.key_in = '0;
        #1;
        checks++;
        if ({bus128.busy, bus128.done, bus128.key_valid} !== 3'b000 || bus128.w !== '0) begin
            errors++; $display("FAIL reset128: busy/done/kv=%b w_nonzero=%0d required 000/0",
                               {bus128.busy, bus128.done, bus128.key_valid}, bus128.w != '0);
        end
        checks++;
        if ({bus192.busy, bus192.done, bus192.key_valid} !== 3'b000 || bus192.w !== '0) begin
            errors++; $display("FAIL reset192: busy/done/kv=%b required 000 with w zero",
                               {bus192.busy, bus192.done, bus192.key_valid});
        end
        checks++;
        if ({bus256.busy, bus256.done, bus256.key_valid} !== 3'b000 || bus256.w !== '0) begin
            errors++; $display("FAIL reset256: busy/done/kv=%b required 000 with w zero",
                               {bus256.busy, bus256.done, bus256.key_valid});
        end
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_aes128();
        int lat, bad;
        run128(KEY128, lat);
        checks++;
        if (lat !== 40) begin errors++; $display("FAIL aes128_latency: got %0d required 40", lat); end
        checks++;
        if (bus128.w[32*4 +: 32] !== 32'ha0fafe17) begin
            errors++; $display("FAIL aes128_w4: got %h required a0fafe17", bus128.w[32*4 +: 32]);
        end
        checks++;
        if (bus128.w[32*43 +: 32] !== 32'hb6630ca6) begin
            errors++; $display("FAIL aes128_w43: got %h required b6630ca6", bus128.w[32*43 +: 32]);
        end
        @(negedge clk);
        checks++;
        if (bus128.done !== 1'b0 || bus128.key_valid !== 1'b1) begin
            errors++; $display("FAIL aes128_done_pulse: done=%b kv=%b required 0/1", bus128.done, bus128.key_valid);
        end
        ref_expand(4, KEY128);
        bad = 0;
        for (int j = 0; j < 44; j++) if (bus128.w[32*j +: 32] !== ref_w[j]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL aes128_model: %0d words differ, required 0", bad); end
    endtask

    task automatic test_aes192();
        int lat, bad;
        run192(KEY192, lat);
        checks++;
        if (lat !== 46) begin errors++; $display("FAIL aes192_latency: got %0d required 46", lat); end
        checks++;
        if (bus192.w[32*6 +: 32] !== 32'hfe0c91f7) begin
            errors++; $display("FAIL aes192_w6: got %h required fe0c91f7", bus192.w[32*6 +: 32]);
        end
        checks++;
        if (bus192.w[32*51 +: 32] !== 32'h01002202) begin
            errors++; $display("FAIL aes192_w51: got %h required 01002202", bus192.w[32*51 +: 32]);
        end
        ref_expand(6, KEY192);
        bad = 0;
        for (int j = 0; j < 52; j++) if (bus192.w[32*j +: 32] !== ref_w[j]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL aes192_model: %0d words differ, required 0", bad); end
    endtask

    task automatic test_aes256();
        int lat;
        logic [127:0] ct;
        run256(KEY256, lat);
        checks++;
        if (lat !== 52) begin errors++; $display("FAIL aes256_latency: got %0d required 52", lat); end
        checks++;
        if (bus256.w[32*8 +: 32] !== 32'h9ba35411 || bus256.w[32*9 +: 32] !== 32'h8e6925af) begin
            errors++; $display("FAIL aes256_w8_w9: got %h %h required 9ba35411 8e6925af",
                               bus256.w[32*8 +: 32], bus256.w[32*9 +: 32]);
        end
        checks++;
        if (bus256.w[32*59 +: 32] !== 32'h706c631e) begin
            errors++; $display("FAIL aes256_w59: got %h required 706c631e", bus256.w[32*59 +: 32]);
        end
        for (int j = 0; j < 60; j++) rk[j] = bus256.w[32*j +: 32];
        ct = encrypt(128'h6bc1bee22e409f96e93d7e117393172a);
        checks++;
        if (ct !== 128'hf3eed1bdb5d2a03c064b5a7e3db181f8) begin
            errors++; $display("FAIL aes256_cipher: got %h required f3eed1bdb5d2a03c064b5a7e3db181f8", ct);
        end
        @(negedge clk);
        checks++;
        if (bus256.done !== 1'b0 || bus256.key_valid !== 1'b1) begin
            errors++; $display("FAIL aes256_done_pulse: done=%b kv=%b required 0/1", bus256.done, bus256.key_valid);
        end
    endtask

    task automatic test_random_keys();
        int lat, bad;
        logic [255:0] key;
        for (int n = 0; n < 4; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run256(key, lat);
            ref_expand(8, key);
            bad = 0;
            for (int j = 0; j < 60; j++) if (bus256.w[32*j +: 32] !== ref_w[j]) bad++;
            checks++;
            if (bad != 0 || lat != 52) begin
                errors++; $display("FAIL random256_%0d: %0d words differ, latency %0d, required 0 and 52", n, bad, lat);
            end
            run128(key, lat);
            ref_expand(4, {key[255:128], 128'h0});
            bad = 0;
            for (int j = 0; j < 44; j++) if (bus128.w[32*j +: 32] !== ref_w[j]) bad++;
            checks++;
            if (bad != 0 || lat != 40) begin
                errors++; $display("FAIL random128_%0d: %0d words differ, latency %0d, required 0 and 40", n, bad, lat);
            end
        end
    endtask

    task automatic test_restart_ignored();
        int lat, bad;
        @(negedge clk); bus256.key_in = KEY256; bus256.start = 1'b1;
        @(posedge clk); @(negedge clk); bus256.start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); @(negedge clk);
            if (c == 10) begin
                bus256.start = 1'b1;
                bus256.key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            end else if (c == 11) begin
                bus256.start = 1'b0;
            end
            if (bus256.done) begin lat = c; break; end
        end
        checks++;
        if (lat !== 52) begin errors++; $display("FAIL restart_latency: got %0d required 52", lat); end
        ref_expand(8, KEY256);
        bad = 0;
        for (int j = 0; j < 60; j++) if (bus256.w[32*j +: 32] !== ref_w[j]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL restart_result: %0d words differ, required 0", bad); end
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk); bus256.key_in = KEY256; bus256.start = 1'b1;
        @(posedge clk); @(negedge clk); bus256.start = 1'b0;
        for (int c = 1; c <= 20; c++) begin @(posedge clk); @(negedge clk); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus256.busy, bus256.done, bus256.key_valid} !== 3'b000 || bus256.w !== '0) begin
            errors++; $display("FAIL reset_mid_async: busy/done/kv=%b w_nonzero=%0d required 000/0",
                               {bus256.busy, bus256.done, bus256.key_valid}, bus256.w != '0);
        end
        @(negedge clk); rst_n = 1'b1;
        run256(KEY256, lat);
        checks++;
        if (lat !== 52 || bus256.w[32*59 +: 32] !== 32'h706c631e) begin
            errors++; $display("FAIL reset_mid_rerun: latency %0d w59 %h required 52 706c631e",
                               lat, bus256.w[32*59 +: 32]);
        end
    endtask

    task automatic test_back_to_back();
        int lat, lat2, bad;
        @(negedge clk); bus256.key_in = KEY256; bus256.start = 1'b1;
        @(posedge clk); @(negedge clk);
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus256.done) begin lat = c; break; end
        end
        checks++;
        if (lat !== 52 || bus256.key_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_first: latency %0d kv %b required 52 and 1", lat, bus256.key_valid);
        end
        @(posedge clk); @(negedge clk); bus256.start = 1'b0;
        checks++;
        if (bus256.key_valid !== 1'b0 || bus256.busy !== 1'b1) begin
            errors++; $display("FAIL b2b_accept: kv=%b busy=%b required 0/1", bus256.key_valid, bus256.busy);
        end
        lat2 = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus256.key_valid) begin lat2 = c; break; end
        end
        ref_expand(8, KEY256);
        bad = 0;
        for (int j = 0; j < 60; j++) if (bus256.w[32*j +: 32] !== ref_w[j]) bad++;
        checks++;
        if (lat2 !== 52 || bad != 0) begin
            errors++; $display("FAIL b2b_second: kv rose after %0d cycles, %0d words differ, required 52 and 0", lat2, bad);
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_random_keys();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
